// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, port indices and
// default bus widths.
package dmem_arbiter_pkg;

  localparam int ADDR_W_DEF = 64;
  localparam int DATA_W_DEF = 64;

  localparam logic PORT_PIPE = 1'b0;
  localparam logic PORT_LOAD = 1'b1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and data_memory signals of the arbiter. The slave modport is the
// arbiter's view; the master modport is the requester/memory side.
interface dmem_arbiter_if
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              done0;
  logic              done1;
  logic [DATA_W-1:0] rdata;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, done0, done1, rdata, mem_en, mem_addr, mem_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, done0, done1, rdata, mem_en, mem_addr, mem_wdata
  );

endinterface

// File: rtl/dmem_prio_sel.sv
// Fixed-priority winner select (pipeline port first) with a starvation counter
// that force-grants the loader port after STARVE_LIMIT consecutive losses.
module dmem_prio_sel
  import dmem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic arb_en,
  output logic winner
);

  logic [3:0] starve_cnt;
  logic       starved;

  always_comb begin
    starved = (starve_cnt == 4'(STARVE_LIMIT));
    winner  = (req1 && (!req0 || starved)) ? PORT_LOAD : PORT_PIPE;
  end

  // Counter only moves on an actual grant; a lone port-0 request leaves it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (arb_en && (req0 || req1)) begin
      if (winner == PORT_LOAD)
        starve_cnt <= '0;
      else if (req1 && !starved)
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of data_memory: grant, one-cycle memory access, done.
// Owns the memory write enable, which is high only in the ACCESS cycle of a write.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = 4
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  state_t            state;
  logic              winner;
  logic              owner;
  logic              gnt0;
  logic              gnt1;
  logic              done0;
  logic              done1;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rdata;

  dmem_prio_sel #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_prio_sel (
    .clk    (clk),
    .rst    (rst),
    .req0   (bus.req0),
    .req1   (bus.req1),
    .arb_en (state == ST_IDLE),
    .winner (winner)
  );

  // The memory-side registers double as the request latch: they are loaded at the
  // grant edge and hold until the next grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      owner     <= PORT_PIPE;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      mem_en    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
    end else begin
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      done0  <= 1'b0;
      done1  <= 1'b0;
      mem_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.req0 || bus.req1) begin
            owner     <= winner;
            gnt0      <= (winner == PORT_PIPE);
            gnt1      <= (winner == PORT_LOAD);
            mem_en    <= (winner == PORT_LOAD) ? bus.we1    : bus.we0;
            mem_addr  <= (winner == PORT_LOAD) ? bus.addr1  : bus.addr0;
            mem_wdata <= (winner == PORT_LOAD) ? bus.wdata1 : bus.wdata0;
            state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          rdata <= bus.mem_rdata;
          done0 <= (owner == PORT_PIPE);
          done1 <= (owner == PORT_LOAD);
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.gnt0      = gnt0;
  assign bus.gnt1      = gnt1;
  assign bus.done0     = done0;
  assign bus.done1     = done1;
  assign bus.rdata     = rdata;
  assign bus.mem_en    = mem_en;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;

endmodule
